seg_scan_ctrl: RTL and testbench



---
 rtl/seg_scan_ctrl.sv | 176 +++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Score display controller: converts player/dealer binary scores to BCD with a
// sequential shift-add-3 converter and time-multiplexes four 7-segment digits.
module seg_scan_ctrl #(
  parameter logic [15:0] SCAN_DIV = 16'd50000,
  parameter int          CW       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [5:0] player_val,
  input  logic [5:0] dealer_val,
  input  logic       dealer_hide,
  output logic       busy,
  output logic       done,
  output logic [3:0] bcd_code,
  output logic [3:0] seg_sel
);

  // Handshake: load is accepted only on a cycle where busy is low; busy rises on
  // the accepting edge and falls on the edge that commits the digits, where done
  // pulses for one cycle. Loads seen while busy (including the falling edge) are dropped.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV_D = 2'd1,
    CONV_P = 2'd2
  } state_t;

  localparam logic [CW-1:0] LP_TERM = CW'(SCAN_DIV - 16'd1);

  state_t        r_state;
  state_t        w_state_next;
  logic          w_start;
  logic          w_mid;
  logic          w_commit;
  logic          w_last;

  logic [2:0]    r_step;
  logic [5:0]    r_cap_p;
  logic [13:0]   r_sr;
  logic [3:0]    w_tens_adj;
  logic [3:0]    w_ones_adj;
  logic [13:0]   w_sr_adj;
  logic [13:0]   w_sr_shift;
  logic [3:0]    r_tmp_d_tens;
  logic [3:0]    r_tmp_d_ones;
  logic [3:0]    r_dig [4];
  logic          r_busy;
  logic          r_done;

  logic [CW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic [1:0]    w_idx_next;
  logic          w_wrap;
  logic [3:0]    w_dig_val;
  logic          w_blank;
  logic [3:0]    r_bcd;
  logic [3:0]    r_sel;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_mid        = 1'b0;
    w_commit     = 1'b0;
    w_last       = (r_step == 3'd5);
    case (r_state)
      IDLE: begin
        if (load) begin
          w_start      = 1'b1;
          w_state_next = CONV_D;
        end
      end
      CONV_D: begin
        if (w_last) begin
          w_mid        = 1'b1;
          w_state_next = CONV_P;
        end
      end
      CONV_P: begin
        if (w_last) begin
          w_commit     = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------- converter
  always_comb begin
    w_tens_adj = (r_sr[13:10] >= 4'd5) ? r_sr[13:10] + 4'd3 : r_sr[13:10];
    w_ones_adj = (r_sr[9:6]   >= 4'd5) ? r_sr[9:6]   + 4'd3 : r_sr[9:6];
    w_sr_adj   = {w_tens_adj, w_ones_adj, r_sr[5:0]};
    w_sr_shift = w_sr_adj << 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step       <= 3'd0;
      r_cap_p      <= 6'd0;
      r_sr         <= 14'd0;
      r_tmp_d_tens <= 4'd0;
      r_tmp_d_ones <= 4'd0;
      r_dig[0]     <= 4'd0;
      r_dig[1]     <= 4'd0;
      r_dig[2]     <= 4'd0;
      r_dig[3]     <= 4'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_start) begin
        r_cap_p <= player_val;
        r_sr    <= {8'd0, dealer_val};
        r_step  <= 3'd0;
        r_busy  <= 1'b1;
      end else if (r_state != IDLE) begin
        r_step <= w_last ? 3'd0 : r_step + 3'd1;
        if (w_mid) begin
          // Dealer result parks here so the player pass can reuse the shifter.
          r_tmp_d_tens <= w_sr_shift[13:10];
          r_tmp_d_ones <= w_sr_shift[9:6];
          r_sr         <= {8'd0, r_cap_p};
        end else if (w_commit) begin
          r_dig[0] <= w_sr_shift[9:6];
          r_dig[1] <= w_sr_shift[13:10];
          r_dig[2] <= r_tmp_d_ones;
          r_dig[3] <= r_tmp_d_tens;
          r_sr     <= w_sr_shift;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
        end else begin
          r_sr <= w_sr_shift;
        end
      end
    end
  end

  // --------------------------------------------------------------- scan
  always_comb begin
    w_wrap     = (r_presc == LP_TERM);
    w_idx_next = r_idx + 2'd1;
    w_dig_val  = r_dig[w_idx_next];
    // Odd slots are tens digits: suppress a leading zero there.
    w_blank    = (w_idx_next[0] && (w_dig_val == 4'd0)) ||
                 (w_idx_next[1] && dealer_hide);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= 2'd0;
      r_bcd   <= 4'd0;
      r_sel   <= 4'b1111;
    end else if (w_wrap) begin
      r_presc <= '0;
      r_idx   <= w_idx_next;
      r_bcd   <= w_dig_val;
      r_sel   <= w_blank ? 4'b1111 : ~(4'b0001 << w_idx_next);
    end else begin
      r_presc <= r_presc + CW'(1);
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign bcd_code = r_bcd;
  assign seg_sel  = r_sel;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl; expected outputs come from an edge-counted
// model using score/10 and score%10 with a queue of accepted score pairs.
module tb_seg_scan_ctrl;

  localparam int SDI = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic [5:0] player_val;
  logic [5:0] dealer_val;
  logic       dealer_hide;
  logic       busy;
  logic       done;
  logic [3:0] bcd_code;
  logic [3:0] seg_sel;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.SCAN_DIV(16'(SDI)), .CW(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .player_val  (player_val),
    .dealer_val  (dealer_val),
    .dealer_hide (dealer_hide),
    .busy        (busy),
    .done        (done),
    .bcd_code    (bcd_code),
    .seg_sel     (seg_sel)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  int          e;
  int          m_p, m_d;
  int          m_cnt;
  bit          m_busy;
  logic [11:0] exp_q[$];
  logic [3:0]  exp_sel, exp_bcd;
  logic        exp_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("busy", {31'd0, busy}, {31'd0, m_busy});
    check("done", {31'd0, done}, {31'd0, exp_done});
    check("seg_sel", {28'd0, seg_sel}, {28'd0, exp_sel});
    check("bcd_code", {28'd0, bcd_code}, {28'd0, exp_bcd});
  endtask

  // Called at a negedge: applies inputs for the next posedge, then checks.
  task automatic cycle(input logic ld, input int p, input int d, input logic hide);
    int slot, val;
    logic [11:0] pr;
    load        = ld;
    player_val  = p[5:0];
    dealer_val  = d[5:0];
    dealer_hide = hide;
    @(posedge clk);
    e++;
    if (e % SDI == 0) begin
      slot = (e / SDI) % 4;
      case (slot)
        0:       val = m_p % 10;
        1:       val = m_p / 10;
        2:       val = m_d % 10;
        default: val = m_d / 10;
      endcase
      exp_bcd = val[3:0];
      if (((slot % 2 == 1) && val == 0) || (slot >= 2 && hide)) exp_sel = 4'b1111;
      else exp_sel = ~(4'b0001 << slot);
    end
    exp_done = 1'b0;
    if (!m_busy) begin
      if (ld) begin
        m_busy = 1'b1;
        m_cnt  = 0;
        exp_q.push_back({p[5:0], d[5:0]});
      end
    end else begin
      m_cnt++;
      if (m_cnt == 12) begin
        m_busy   = 1'b0;
        exp_done = 1'b1;
        if (exp_q.size() > 0) begin
          pr  = exp_q.pop_front();
          m_p = int'(pr[11:6]);
          m_d = int'(pr[5:0]);
        end
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n, input logic hide);
    for (int i = 0; i < n; i++)
      cycle(1'b0, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), hide);
  endtask

  task automatic do_reset(input int hold);
    rst_n    = 1'b0;
    load     = 1'b0;
    e        = 0;
    m_p      = 0;
    m_d      = 0;
    m_cnt    = 0;
    m_busy   = 1'b0;
    exp_q.delete();
    exp_sel  = 4'b1111;
    exp_bcd  = 4'd0;
    exp_done = 1'b0;
    repeat (hold) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
  endtask

  initial begin
    int ld_len, p, d;
    logic hide;
    load        = 1'b0;
    player_val  = 6'd0;
    dealer_val  = 6'd0;
    dealer_hide = 1'b0;
    rst_n       = 1'b0;

    do_reset(3);
    idle(20, 1'b0);

    cycle(1'b1, 21, 17, 1'b0);
    idle(32, 1'b0);

    cycle(1'b1, 5, 63, 1'b0);
    idle(32, 1'b0);

    // second load mid-conversion must be dropped
    cycle(1'b1, 42, 9, 1'b0);
    idle(3, 1'b0);
    cycle(1'b1, 11, 33, 1'b0);
    idle(30, 1'b0);

    cycle(1'b1, 8, 20, 1'b1);
    idle(30, 1'b1);
    idle(20, 1'b0);

    // reset in the middle of a conversion
    cycle(1'b1, 37, 52, 1'b0);
    idle(6, 1'b0);
    do_reset(2);
    idle(20, 1'b0);
    cycle(1'b1, 19, 26, 1'b0);
    idle(30, 1'b0);

    for (int v = 0; v < 64; v++) begin
      cycle(1'b1, v, 63 - v, 1'b0);
      idle(28, 1'b0);
    end

    for (int k = 0; k < 150; k++) begin
      ld_len = int'($urandom_range(1, 16));
      p      = int'($urandom_range(0, 63));
      d      = int'($urandom_range(0, 63));
      hide   = 1'($urandom_range(0, 1));
      for (int j = 0; j < ld_len; j++) begin
        if ($urandom_range(0, 3) == 0) p = int'($urandom_range(0, 63));
        cycle(1'b1, p, d, hide);
      end
      idle(int'($urandom_range(0, 24)), hide);
    end
    idle(30, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
